controlador_comparador: RTL

Sequencer that compares two multi-chunk words using the team's single 2-bit equality comparator (`comparador_2bits`, output X = 1 when A == B). The block drives the comparator's A/B inputs once per clock, most-significant chunk first, and exits early on the first mismatch. It reports the equality result and the index of the first differing chunk through a start/busy/done handshake. It sits between a requesting datapath and one shared `comparador_2bits` instance.

---
 rtl/controlador_comparador.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/controlador_comparador.sv
// controlador_comparador
// Sequences a chunk-by-chunk equality check of two words through one shared
// 2-bit comparator (comparador_2bits). It scans from the most significant
// chunk down and stops at the first chunk that differs. A start/busy/done
// handshake frames each operation. The result (equal, mismatch_idx) is held
// until the next operation completes.

module controlador_comparador #(
    parameter int N_CHUNKS = 4,
    parameter int IDX_W    = $clog2(N_CHUNKS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2*N_CHUNKS-1:0] word_a,
    input  logic [2*N_CHUNKS-1:0] word_b,
    output logic                  busy,
    output logic                  done,
    output logic                  equal,
    output logic [IDX_W-1:0]      mismatch_idx,
    output logic [1:0]            cmp_a,
    output logic [1:0]            cmp_b,
    input  logic                  cmp_x
);

    localparam int               W        = 2 * N_CHUNKS;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CHUNKS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [W-1:0]     wordA_q, wordA_d;
    logic [W-1:0]     wordB_q, wordB_d;
    logic             equal_q, equal_d;
    logic [IDX_W-1:0] mismatchIdx_q, mismatchIdx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [1:0]       cmpA_q, cmpA_d;
    logic [1:0]       cmpB_q, cmpB_d;

    // Returns the 2-bit chunk at position i of a word (chunk 0 is the LSBs).
    function automatic logic [1:0] chunkOf(input logic [W-1:0] w,
                                           input logic [IDX_W-1:0] i);
        chunkOf = w[{i, 1'b0} +: 2];
    endfunction

    // Next-state logic. The comparator operands are registered together
    // with the state, so they are already valid in the first COMPARE cycle
    // and are zero again on the DONE and IDLE cycles.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        wordA_d       = wordA_q;
        wordB_d       = wordB_q;
        equal_d       = equal_q;
        mismatchIdx_d = mismatchIdx_q;
        busy_d        = busy_q;
        done_d        = done_q;
        cmpA_d        = cmpA_q;
        cmpB_d        = cmpB_q;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                done_d = 1'b0;
                cmpA_d = 2'b00;
                cmpB_d = 2'b00;
                if (start) begin
                    wordA_d = word_a;
                    wordB_d = word_b;
                    idx_d   = LAST_IDX;
                    cmpA_d  = chunkOf(word_a, LAST_IDX);
                    cmpB_d  = chunkOf(word_b, LAST_IDX);
                    busy_d  = 1'b1;
                    state_d = COMPARE;
                end
            end

            COMPARE: begin
                if (!cmp_x) begin
                    equal_d       = 1'b0;
                    mismatchIdx_d = idx_q;
                    busy_d        = 1'b0;
                    done_d        = 1'b1;
                    cmpA_d        = 2'b00;
                    cmpB_d        = 2'b00;
                    state_d       = DONE;
                end else if (idx_q == '0) begin
                    equal_d       = 1'b1;
                    mismatchIdx_d = '0;
                    busy_d        = 1'b0;
                    done_d        = 1'b1;
                    cmpA_d        = 2'b00;
                    cmpB_d        = 2'b00;
                    state_d       = DONE;
                end else begin
                    idx_d  = idx_q - IDX_W'(1);
                    cmpA_d = chunkOf(wordA_q, idx_q - IDX_W'(1));
                    cmpB_d = chunkOf(wordB_q, idx_q - IDX_W'(1));
                end
            end

            DONE: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                cmpA_d  = 2'b00;
                cmpB_d  = 2'b00;
                state_d = IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                done_d  = 1'b0;
                cmpA_d  = 2'b00;
                cmpB_d  = 2'b00;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any operation and clears the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            wordA_q       <= '0;
            wordB_q       <= '0;
            equal_q       <= 1'b0;
            mismatchIdx_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            cmpA_q        <= 2'b00;
            cmpB_q        <= 2'b00;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            wordA_q       <= wordA_d;
            wordB_q       <= wordB_d;
            equal_q       <= equal_d;
            mismatchIdx_q <= mismatchIdx_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            cmpA_q        <= cmpA_d;
            cmpB_q        <= cmpB_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign equal        = equal_q;
    assign mismatch_idx = mismatchIdx_q;
    assign cmp_a        = cmpA_q;
    assign cmp_b        = cmpB_q;

endmodule
